// File: rtl/silife_max7219_rx.sv
// Receive-side model of a daisy-chained MAX7219 string: samples CS/SCK/MOSI on clk,
// commits one 16-bit command per device on each armed CS rise, and offers registered readback.
// Ports: clk/reset; i_cs/i_sck/i_mosi SPI inputs; i_rd_device/i_rd_row select; o_rd_* readback
// (1-cycle latency); o_frame_strobe/o_len_error pulses; o_err_sticky; o_frame_count.
module silife_max7219_rx #(
  parameter int DEVICES = 16,
  localparam int DW = $clog2(DEVICES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cs,
  input  logic          i_sck,
  input  logic          i_mosi,
  input  logic [DW-1:0] i_rd_device,
  input  logic [2:0]    i_rd_row,
  output logic [7:0]    o_rd_data,
  output logic [3:0]    o_rd_intensity,
  output logic [2:0]    o_rd_scan_limit,
  output logic [7:0]    o_rd_decode,
  output logic          o_rd_shutdown_n,
  output logic          o_rd_test,
  output logic          o_frame_strobe,
  output logic          o_len_error,
  output logic          o_err_sticky,
  output logic [15:0]   o_frame_count
);

  localparam int NB = 16 * DEVICES;
  localparam int CW = $clog2(NB + 2);

  // Synchronisers plus one delay stage for edge detection
  logic r_cs_s1, r_cs_s2, r_cs_d;
  logic r_sck_s1, r_sck_s2, r_sck_d;
  logic r_mosi_s1, r_mosi_s2;
  // r_vld[2] marks that r_cs_d/r_sck_d hold real samples rather than reset values;
  // without it a CS held low through reset would look like a fresh falling edge.
  logic [2:0] r_vld;

  logic [NB-1:0] r_sr;
  logic [CW-1:0] r_bit_cnt;
  logic          r_armed;

  logic [7:0] r_digit [DEVICES][8];
  logic [7:0] r_decode [DEVICES];
  logic [3:0] r_intensity [DEVICES];
  logic [2:0] r_scan_limit [DEVICES];
  logic       r_shutdown_n [DEVICES];
  logic       r_test [DEVICES];

  logic w_cs_fall, w_cs_rise, w_sck_rise;
  assign w_cs_fall  = r_vld[2] &  r_cs_d  & ~r_cs_s2;
  assign w_cs_rise  = r_vld[2] & ~r_cs_d  &  r_cs_s2;
  assign w_sck_rise = r_vld[2] & ~r_sck_d &  r_sck_s2 & ~r_cs_s2;

  function automatic logic [2:0] row_of(input logic [3:0] addr);
    return 3'(addr - 4'd1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_s1 <= 1'b1; r_cs_s2 <= 1'b1; r_cs_d <= 1'b1;
      r_sck_s1 <= 1'b0; r_sck_s2 <= 1'b0; r_sck_d <= 1'b0;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
      r_vld <= '0;
      r_sr <= '0;
      r_bit_cnt <= '0;
      r_armed <= 1'b0;
      o_frame_strobe <= 1'b0;
      o_len_error <= 1'b0;
      o_err_sticky <= 1'b0;
      o_frame_count <= '0;
      for (int k = 0; k < DEVICES; k++) begin
        for (int r = 0; r < 8; r++) r_digit[k][r] <= '0;
        r_decode[k] <= '0;
        r_intensity[k] <= '0;
        r_scan_limit[k] <= '0;
        r_shutdown_n[k] <= 1'b0;
        r_test[k] <= 1'b0;
      end
    end else begin
      r_cs_s1 <= i_cs;     r_cs_s2 <= r_cs_s1;     r_cs_d <= r_cs_s2;
      r_sck_s1 <= i_sck;   r_sck_s2 <= r_sck_s1;   r_sck_d <= r_sck_s2;
      r_mosi_s1 <= i_mosi; r_mosi_s2 <= r_mosi_s1;
      r_vld <= {r_vld[1:0], 1'b1};
      o_frame_strobe <= 1'b0;
      o_len_error <= 1'b0;

      // CS edges take priority over a coincident SCK rise
      if (w_cs_fall) begin
        r_bit_cnt <= '0;
        r_armed <= 1'b1;
      end else if (w_cs_rise) begin
        if (r_armed) begin
          r_armed <= 1'b0;
          if (r_bit_cnt == CW'(NB)) begin
            o_frame_strobe <= 1'b1;
            o_frame_count <= o_frame_count + 16'd1;
            // Word k sits at sr[16k+15:16k]; the last word shifted lands in device 0
            for (int k = 0; k < DEVICES; k++) begin
              case (r_sr[16*k+8 +: 4])
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                  r_digit[k][row_of(r_sr[16*k+8 +: 4])] <= r_sr[16*k +: 8];
                4'h9: r_decode[k] <= r_sr[16*k +: 8];
                4'hA: r_intensity[k] <= r_sr[16*k +: 4];
                4'hB: r_scan_limit[k] <= r_sr[16*k +: 3];
                4'hC: r_shutdown_n[k] <= r_sr[16*k];
                4'hF: r_test[k] <= r_sr[16*k];
                default: ; // 0x0 no-op, 0xD/0xE ignored
              endcase
            end
          end else begin
            o_len_error <= 1'b1;
            o_err_sticky <= 1'b1;
          end
        end
      end else if (w_sck_rise) begin
        r_sr <= {r_sr[NB-2:0], r_mosi_s2};
        if (r_bit_cnt != CW'(NB + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rd_data <= '0;
      o_rd_intensity <= '0;
      o_rd_scan_limit <= '0;
      o_rd_decode <= '0;
      o_rd_shutdown_n <= 1'b0;
      o_rd_test <= 1'b0;
    end else begin
      o_rd_data <= r_digit[i_rd_device][i_rd_row];
      o_rd_intensity <= r_intensity[i_rd_device];
      o_rd_scan_limit <= r_scan_limit[i_rd_device];
      o_rd_decode <= r_decode[i_rd_device];
      o_rd_shutdown_n <= r_shutdown_n[i_rd_device];
      o_rd_test <= r_test[i_rd_device];
    end
  end

endmodule

// File: tb/tb_silife_max7219_rx.sv
module tb_silife_max7219_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_cs = 1'b1, i_sck = 1'b0, i_mosi = 1'b0;
  logic [0:0] i_rd_device = '0;
  logic [2:0] i_rd_row = '0;
  logic [7:0] o_rd_data, o_rd_decode;
  logic [3:0] o_rd_intensity;
  logic [2:0] o_rd_scan_limit;
  logic       o_rd_shutdown_n, o_rd_test, o_frame_strobe, o_len_error, o_err_sticky;
  logic [15:0] o_frame_count;

  int n_vec = 0, n_err = 0;
  int n_strobe = 0, n_lenerr = 0;
  int s0, e0;

  always #5 clk = ~clk;

  silife_max7219_rx #(.DEVICES(2)) dut (
    .clk(clk), .reset(reset), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .i_rd_device(i_rd_device), .i_rd_row(i_rd_row),
    .o_rd_data(o_rd_data), .o_rd_intensity(o_rd_intensity),
    .o_rd_scan_limit(o_rd_scan_limit), .o_rd_decode(o_rd_decode),
    .o_rd_shutdown_n(o_rd_shutdown_n), .o_rd_test(o_rd_test),
    .o_frame_strobe(o_frame_strobe), .o_len_error(o_len_error),
    .o_err_sticky(o_err_sticky), .o_frame_count(o_frame_count)
  );

  always @(posedge clk) begin
    if (o_frame_strobe) n_strobe++;
    if (o_len_error) n_lenerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop CS and clock out the low n bits of d, MSB first; CS is left low
  task automatic send_bits(input logic [63:0] d, input int n);
    i_cs = 1'b0;
    clks(4);
    for (int i = n - 1; i >= 0; i--) begin
      i_mosi = d[i];
      clks(4);
      i_sck = 1'b1;
      clks(4);
      i_sck = 1'b0;
    end
    clks(4);
  endtask

  task automatic raise_cs;
    i_cs = 1'b1;
    clks(12);
  endtask

  task automatic rd(input int dev, input int row);
    i_rd_device = 1'(dev);
    i_rd_row = 3'(row);
    clks(2);
  endtask

  initial begin
    clks(3);
    reset = 1'b0;
    clks(6);

    // Reset state
    rd(1, 0);
    chk("rst_data", {24'd0, o_rd_data}, 32'h0);
    chk("rst_intensity", {28'd0, o_rd_intensity}, 32'h0);
    chk("rst_scan", {29'd0, o_rd_scan_limit}, 32'h0);
    chk("rst_decode", {24'd0, o_rd_decode}, 32'h0);
    chk("rst_shutdown_n", {31'd0, o_rd_shutdown_n}, 32'h0);
    chk("rst_test", {31'd0, o_rd_test}, 32'h0);
    chk("rst_count", {16'd0, o_frame_count}, 32'h0);
    chk("rst_sticky", {31'd0, o_err_sticky}, 32'h0);

    // Frame 1: dev1 <- 0x0155 (row0=0x55), dev0 <- 0x0C01 (shutdown_n=1)
    s0 = n_strobe; e0 = n_lenerr;
    send_bits(64'h0155_0C01, 32);
    raise_cs();
    chk("f1_strobes", n_strobe - s0, 1);
    chk("f1_lenerr", n_lenerr - e0, 0);
    chk("f1_count", {16'd0, o_frame_count}, 32'd1);
    rd(1, 0); chk("f1_dev1_row0", {24'd0, o_rd_data}, 32'h55);
    chk("f1_dev1_shdn", {31'd0, o_rd_shutdown_n}, 32'h0);
    rd(0, 0); chk("f1_dev0_shdn", {31'd0, o_rd_shutdown_n}, 32'h1);
    chk("f1_dev0_row0", {24'd0, o_rd_data}, 32'h0);

    // Frame 2: dev1 intensity=0xF, dev0 row7=0xAA
    send_bits(64'h0AFF_08AA, 32);
    raise_cs();
    chk("f2_count", {16'd0, o_frame_count}, 32'd2);
    rd(1, 0); chk("f2_dev1_int", {28'd0, o_rd_intensity}, 32'hF);
    chk("f2_dev1_row0", {24'd0, o_rd_data}, 32'h55);
    rd(0, 7); chk("f2_dev0_row7", {24'd0, o_rd_data}, 32'hAA);
    chk("f2_dev0_int", {28'd0, o_rd_intensity}, 32'h0);

    // Short frame: 31 bits
    s0 = n_strobe; e0 = n_lenerr;
    send_bits(64'h0A05_0101, 31);
    raise_cs();
    chk("short_lenerr", n_lenerr - e0, 1);
    chk("short_strobe", n_strobe - s0, 0);
    chk("short_sticky", {31'd0, o_err_sticky}, 32'h1);
    chk("short_count", {16'd0, o_frame_count}, 32'd2);
    rd(1, 0); chk("short_dev1_int", {28'd0, o_rd_intensity}, 32'hF);

    // Long frame: 40 bits, counter saturates at 33
    s0 = n_strobe; e0 = n_lenerr;
    send_bits(64'h00_0000_0012_0155_0C01, 40);
    chk("long_bitcnt", 32'(dut.r_bit_cnt), 32'd33);
    raise_cs();
    chk("long_lenerr", n_lenerr - e0, 1);
    chk("long_strobe", n_strobe - s0, 0);
    chk("long_count", {16'd0, o_frame_count}, 32'd2);

    // Valid frame after errors: dev1 scan_limit=5, dev0 intensity=3
    s0 = n_strobe;
    send_bits(64'h0B05_0A03, 32);
    raise_cs();
    chk("f3_strobe", n_strobe - s0, 1);
    chk("f3_count", {16'd0, o_frame_count}, 32'd3);
    rd(1, 0); chk("f3_dev1_scan", {29'd0, o_rd_scan_limit}, 32'h5);
    rd(0, 0); chk("f3_dev0_int", {28'd0, o_rd_intensity}, 32'h3);

    // Decode and test registers: dev1 decode=0xC3, dev0 test=1
    send_bits(64'h09C3_0F01, 32);
    raise_cs();
    chk("f4_count", {16'd0, o_frame_count}, 32'd4);
    rd(1, 0); chk("f4_dev1_decode", {24'd0, o_rd_decode}, 32'hC3);
    chk("f4_dev1_test", {31'd0, o_rd_test}, 32'h0);
    rd(0, 0); chk("f4_dev0_test", {31'd0, o_rd_test}, 32'h1);
    chk("f4_dev0_decode", {24'd0, o_rd_decode}, 32'h0);

    // Reset mid-frame, released with CS low, then CS rises: nothing happens
    s0 = n_strobe; e0 = n_lenerr;
    send_bits(64'h0155_0C01, 20);
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    clks(10);
    raise_cs();
    chk("rst_mid_strobe", n_strobe - s0, 0);
    chk("rst_mid_lenerr", n_lenerr - e0, 0);
    chk("rst_mid_sticky", {31'd0, o_err_sticky}, 32'h0);
    chk("rst_mid_count", {16'd0, o_frame_count}, 32'h0);
    rd(1, 0); chk("rst_mid_dev1_row0", {24'd0, o_rd_data}, 32'h0);
    chk("rst_mid_dev1_int", {28'd0, o_rd_intensity}, 32'h0);
    rd(0, 0); chk("rst_mid_dev0_shdn", {31'd0, o_rd_shutdown_n}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
